// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store request, load probe and dcache write port bundle
interface store_buffer_if;
  logic        st_valid;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        st_misalign;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        dcache_write;
  logic [31:0] dcache_address;
  logic [31:0] dcache_wdata;
  logic [3:0]  dcache_mbe;
  logic        dcache_resp;
  logic        empty;

  modport master (
    output st_valid, st_funct3, st_addr, st_data, ld_valid, ld_addr, dcache_resp,
    input  st_ready, st_misalign, ld_stall, dcache_write, dcache_address,
           dcache_wdata, dcache_mbe, empty
  );

  modport slave (
    input  st_valid, st_funct3, st_addr, st_data, ld_valid, ld_addr, dcache_resp,
    output st_ready, st_misalign, ld_stall, dcache_write, dcache_address,
           dcache_wdata, dcache_mbe, empty
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - circular store buffer draining one write at a time to the dcache
module store_buffer #(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic           write_q, write_d;
  logic [31:0]    addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]     mbe_q, mbe_d;

  logic [31:0]    ent_addr  [DEPTH];
  logic [31:0]    ent_wdata [DEPTH];
  logic [3:0]     ent_mbe   [DEPTH];

  logic           legal, misaligned, push, pop, conflict, st_ready;
  logic [31:0]    new_addr, new_wdata;
  logic [3:0]     new_mbe;
  logic [PW-1:0]  scan_idx;

  always_comb begin
    legal      = 1'b1;
    misaligned = 1'b0;
    new_addr   = {bus.st_addr[31:2], 2'b00};
    new_wdata  = bus.st_data;
    new_mbe    = 4'b1111;
    case (bus.st_funct3)
      3'b000: begin
        new_mbe   = 4'b0001 << bus.st_addr[1:0];
        new_wdata = {4{bus.st_data[7:0]}};
      end
      3'b001: begin
        new_mbe    = 4'b0011 << {bus.st_addr[1], 1'b0};
        new_wdata  = {2{bus.st_data[15:0]}};
        misaligned = bus.st_addr[0];
      end
      3'b010:  misaligned = |bus.st_addr[1:0];
      default: legal = 1'b0;
    endcase
  end

  // Only live entries (head .. head+count-1) are matched, the one being written included.
  always_comb begin
    conflict = 1'b0;
    scan_idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (CW'(i) < count_q &&
          {ent_addr[scan_idx][31:2], bus.ld_addr[1:0]} == bus.ld_addr)
        conflict = 1'b1;
    end
  end

  assign st_ready = count_q < FULL;
  assign push     = bus.st_valid & st_ready & legal & ~misaligned;
  assign pop      = (state_q == WRITE) & bus.dcache_resp;

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mbe_d   = mbe_q;
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    case (state_q)
      IDLE: begin
        addr_d  = ent_addr[head_q];
        wdata_d = ent_wdata[head_q];
        mbe_d   = ent_mbe[head_q];
        if (count_q != '0 && (!bus.ld_valid || conflict || count_q == FULL)) begin
          state_d = WRITE;
          write_d = 1'b1;
        end
      end
      WRITE: begin
        if (bus.dcache_resp) begin
          state_d = IDLE;
          write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mbe_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mbe_q   <= mbe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail_q]  <= new_addr;
      ent_wdata[tail_q] <= new_wdata;
      ent_mbe[tail_q]   <= new_mbe;
    end
  end

  assign bus.st_ready       = st_ready;
  assign bus.st_misalign    = rst & bus.st_valid & misaligned;
  assign bus.ld_stall       = bus.ld_valid & ((state_q == WRITE) | conflict);
  assign bus.dcache_write   = write_q;
  assign bus.dcache_address = addr_q;
  assign bus.dcache_wdata   = wdata_q;
  assign bus.dcache_mbe     = mbe_q;
  assign bus.empty          = (count_q == '0) & (state_q == IDLE);
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered stores; power of two, at least 2.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports, in this order:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- st_valid  in  1  MEM-stage store request.
- st_funct3  in  3  000 sb, 001 sh, 010 sw.
- st_addr  in  32  byte address.
- st_data  in  32  rs2 value, unaligned.
- st_ready  out  1  buffer can accept.
- st_misalign  out  1  one-cycle pulse: misaligned store dropped.
- ld_valid  in  1  MEM-stage load requests dcache.
- ld_addr  in  32  load byte address.
- ld_stall  out  1  load must not issue this cycle.
- dcache_write  out  1  write request.
- dcache_address  out  32  word-aligned address.
- dcache_wdata  out  32  lane-replicated data.
- dcache_mbe  out  4  byte enables.
- dcache_resp  in  1  write complete.
- empty  out  1  no pending or in-flight stores.

Function
REQ-004 SHALL form each entry at enqueue as follows:
- address: {st_addr[31:2], 2'b00}.
- sb: mbe = 4'b0001 << st_addr[1:0]; wdata = {4{st_data[7:0]}}.
- sh: mbe = 4'b0011 << {st_addr[1],1'b0}; wdata = {2{st_data[15:0]}}.
- sw: mbe = 4'b1111; wdata = st_data.
REQ-005 SHALL treat sh with st_addr[0]=1, or sw with st_addr[1:0]!=0, as misaligned: not enqueued, st_misalign=1 for that cycle.
REQ-006 SHALL ignore st_valid with any st_funct3 outside {000,001,010}: no enqueue, no pulse.
REQ-007 SHALL keep a circular FIFO with head, tail and count (0..DEPTH); pointers wrap modulo DEPTH.
REQ-008 SHALL drive st_ready = (count < DEPTH), from registered count only; a same-cycle pop does not free a slot.
REQ-009 SHALL enqueue at the rising edge where st_valid & st_ready & legal store are all true.
REQ-010 SHALL implement drain FSM states IDLE and WRITE.
REQ-011 IDLE -> WRITE SHALL occur when count>0 and (!ld_valid, or conflict, or count==DEPTH); otherwise the FSM stays in IDLE.
REQ-012 In WRITE, dcache_write SHALL be 1, and dcache_address/wdata/mbe SHALL hold the head entry stable until dcache_resp.
REQ-013 On dcache_resp in WRITE, the FSM SHALL pop the head and return to IDLE, giving at least one IDLE cycle between writes.
REQ-014 SHALL ignore dcache_resp while in IDLE.
REQ-015 In IDLE, dcache_write SHALL be 0; address/wdata/mbe SHALL be don't-care to the cache but driven from the head entry.
REQ-016 conflict SHALL be 1 when any valid entry has address[31:2] == ld_addr[31:2], including the entry in flight.
REQ-017 SHALL drive ld_stall = ld_valid & (state==WRITE | conflict).
REQ-018 A store accepted at edge k with the buffer empty and ld_valid=0 SHALL have dcache_write asserted from edge k+1.
REQ-019 On simultaneous enqueue and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-020 SHALL drive empty = (count==0) & (state==IDLE).

Reset
REQ-021 rst=0 SHALL immediately force:
- state to IDLE;
- head, tail and count to 0;
- dcache_write, dcache_address, dcache_wdata, dcache_mbe and st_misalign to 0.
With the buffer empty, st_ready=1, empty=1 and ld_stall=ld_valid&conflict=0.
REQ-022 Reset during WRITE SHALL abandon the in-flight write; a later dcache_resp is ignored.

Verification
REQ-023 sb, addr 0x1003, data 0xAABBCCDD -> dcache_address 0x1000, mbe 1000, wdata 0xDDDDDDDD, dcache_write from next edge.
REQ-024 sh, addr 0x2001 -> st_misalign pulse, count stays 0, no dcache_write; sh addr 0x2002 data 0x1234 -> mbe 1100, wdata 0x12341234.
REQ-025 Fill 2 sw with ld_valid=1, unrelated ld_addr -> st_ready=0 and drain starts because count==DEPTH; a third st_valid is held off until the first dcache_resp edge passes.
REQ-026 Buffered sw to 0x3000; ld_valid, ld_addr 0x3002 -> ld_stall=1, drain starts despite ld_valid, ld_stall clears after resp pops entry.
REQ-027 Delay dcache_resp 5 cycles -> address/wdata/mbe stable for all 5 cycles, ld_stall=1 throughout.
REQ-028 Assert rst mid-WRITE -> dcache_write=0 asynchronously, empty=1, post-reset dcache_resp causes no pop.
